// File: rtl/prod_accum_8x8.sv
`default_nettype none
// ============================================================================
// Module   : prod_accum_8x8
// Brief    : Sums COUNT multiplier products per frame into a saturating
//            accumulator and presents the frame result on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module prod_accum_8x8 #(
  parameter int ACC_W = 24,
  parameter int COUNT = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod_in,
  input  logic             prod_cout,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] prod_cnt
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(COUNT - 1);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cnt;

  logic [ACC_W-1:0] w_op;
  logic [ACC_W:0]   w_sum;

  // Carry-out joins the product as bit 16 of an unsigned 17-bit operand.
  assign w_op  = ACC_W'({prod_cout, prod_in});
  assign w_sum = {1'b0, r_acc} + {1'b0, w_op};

  assign in_ready  = (r_state == ST_ACCUM);
  assign acc_valid = (r_state == ST_HOLD);
  assign acc_out   = r_acc;
  assign overflow  = r_overflow;
  assign prod_cnt  = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (in_valid) begin
            // Overflow is sticky; an all-ones accumulator stays saturated.
            if (w_sum[ACC_W]) begin
              r_acc      <= '1;
              r_overflow <= 1'b1;
            end else begin
              r_acc <= w_sum[ACC_W-1:0];
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (acc_ready) begin
            r_state    <= ST_ACCUM;
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire
